ltc2600_cmd_queue: RTL
======================

LTC2600_CMD_QUEUE -- requirements
Module: ltc2600_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning DAC code width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max clk cycles to wait for write_complete.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  50 MHz clock; rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1, request present) and in_ready (output, 1, FIFO can accept).
REQ-006 SHALL have input ports in_command (4), in_address (4) and in_data (DATA_WIDTH), forming the request word.
REQ-007 SHALL have output ports send_new_cmd (1, single-cycle launch pulse to writer), command (4), address (4) and data (DATA_WIDTH), forming the word presented to the writer.
REQ-008 SHALL have input write_complete (1), the writer done indication.
REQ-009 SHALL have inputs flush (1, discard queued entries) and err_clear (1, clear sticky error).
REQ-010 SHALL have outputs busy (1, FSM not IDLE or FIFO non-empty), fifo_count ($clog2(DEPTH)+1, occupancy) and timeout_err (1, sticky timeout flag).

Function
REQ-011 SHALL accept a word at a rising clk edge when in_valid && in_ready; in_ready = !full; a push is refused when full even if a pop occurs in the same cycle.
REQ-012 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> GAP -> IDLE.
REQ-013 IDLE SHALL pop the FIFO head into the command/address/data output registers when non-empty, entering LAUNCH.
REQ-014 LAUNCH SHALL assert send_new_cmd for exactly one cycle and then enter WAIT.
REQ-015 command/address/data SHALL stay stable from LAUNCH until the next pop.
REQ-016 WAIT SHALL exit to GAP on a rising edge of write_complete, detected with a one-cycle delayed copy; a level held high from the previous command SHALL NOT count.
REQ-017 GAP SHALL last exactly 2 cycles before IDLE, guaranteeing CSB high time between frames.
REQ-018 Latency: a word accepted at edge k into an empty, IDLE queue SHALL produce send_new_cmd high in the cycle after edge k+1.
REQ-019 Simultaneous push and pop with the FIFO not full SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 flush SHALL empty the FIFO at the next edge, take priority over a same-cycle push, and not abort a command in LAUNCH/WAIT/GAP.
REQ-021 err_clear SHALL clear timeout_err; a same-cycle new timeout SHALL win (flag stays set).

Reset
REQ-022 rstn low SHALL immediately force IDLE, empty the FIFO, and zero send_new_cmd, command, address, data, fifo_count, timeout_err and busy; in_ready SHALL be 1 after reset.
REQ-023 Reset asserted mid-WAIT SHALL drop the in-flight word with no retry.

Configuration
REQ-024 Macro LTC2600_CMD_TIMEOUT_EN defined: WAIT SHALL count cycles and, on reaching TIMEOUT_CYCLES without a write_complete rising edge, set timeout_err, drop the word and enter GAP.
REQ-025 Macro LTC2600_CMD_TIMEOUT_EN undefined: no counter; WAIT SHALL wait indefinitely; timeout_err tied 0; TIMEOUT_CYCLES ignored.

Structure
REQ-026 Package ltc2600_pkg SHALL hold the packed cmd_t {command, address, data}, the FSM state enum, and command constants CMD_WRITE_UPDATE_N=4'b0011 and CMD_NOP=4'b1111.
REQ-027 FIFO storage and pointers SHALL be a sub-module ltc2600_cmd_fifo (cmd_t wide, DEPTH deep, synchronous flush); the FSM lives in ltc2600_cmd_queue.

Verification
REQ-028 Push one {0011,0x2,0xABCD}; write_complete pulses 40 cycles later -> one send_new_cmd pulse, outputs = 3/2/ABCD, then IDLE, busy=0.
REQ-029 Push 9 words at DEPTH=8 with write_complete held low -> in_ready=0 after 8 stored (one already popped), fifo_count=8, no loss; all 9 issue in order.
REQ-030 write_complete stuck high from prior command -> next word stays in WAIT until a fresh rising edge.
REQ-031 With LTC2600_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no write_complete -> timeout_err=1 at cycle 16 of WAIT, next word launches; err_clear -> 0.
REQ-032 flush during WAIT with 5 queued -> fifo_count=0 next cycle, current word completes, no further send_new_cmd.
REQ-033 rstn pulsed low mid-WAIT -> all outputs 0 asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/ltc2600_pkg.sv
// Shared types and constants for the LTC2600 command queue.
package ltc2600_pkg;

  localparam int unsigned CMD_W          = 4;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned DEFAULT_DATA_W = 16;

  localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE_N = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_NOP            = 4'b1111;

  // Request word at the default DAC code width.
  typedef struct packed {
    logic [CMD_W-1:0]          command;
    logic [ADDR_W-1:0]         address;
    logic [DEFAULT_DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_GAP
  } state_e;

endpackage

// File: rtl/ltc2600_cmd_fifo.sv
// Command FIFO: DEPTH-deep storage, wrapping pointers, synchronous flush.
// A push is refused when full, even if a pop happens in the same cycle.
module ltc2600_cmd_fifo
  import ltc2600_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $bits(cmd_t)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush overrides any push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  // Storage array needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ltc2600_cmd_queue.sv
// LTC2600 command queue: buffers DAC requests and launches them one at a
// time to the SPI writer (IDLE -> LAUNCH -> WAIT -> GAP -> IDLE).
// Define LTC2600_CMD_TIMEOUT_EN to enable the WAIT timeout and timeout_err.
module ltc2600_cmd_queue
  import ltc2600_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_command,
  input  logic [3:0]                 in_address,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       send_new_cmd,
  output logic [3:0]                 command,
  output logic [3:0]                 address,
  output logic [DATA_WIDTH-1:0]      data,
  input  logic                       write_complete,
  input  logic                       flush,
  input  logic                       err_clear,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       timeout_err
);

  localparam int unsigned WORD_W = CMD_W + ADDR_W + DATA_WIDTH;

  logic [WORD_W-1:0]     fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop;
  state_e                state_q, state_d;
  logic                  send_q, send_d;
  logic [3:0]            command_q, command_d;
  logic [3:0]            address_q, address_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wc_prev_q, wc_prev_d;
  logic                  gap_q, gap_d;
  logic                  wc_rise;

  ltc2600_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata ({in_command, in_address, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready     = !fifo_full;
  assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
  assign wc_rise      = write_complete && !wc_prev_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign send_new_cmd = send_q;
  assign command      = command_q;
  assign address      = address_q;
  assign data         = data_q;

`ifdef LTC2600_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_hit;
  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{err_clear, 32'(TIMEOUT_CYCLES)};
  assign timeout_err = 1'b0;
`endif

  // Launch FSM next-state; output word registers load only on a pop.
  always_comb begin
    state_d   = state_q;
    send_d    = 1'b0;
    command_d = command_q;
    address_d = address_q;
    data_d    = data_q;
    wc_prev_d = write_complete;
    gap_d     = gap_q;
`ifdef LTC2600_CMD_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    tmo_hit       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          {command_d, address_d, data_d} = fifo_rdata;
          send_d  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
`ifdef LTC2600_CMD_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (wc_rise) begin
          state_d = ST_GAP;
          gap_d   = 1'b0;
        end
`ifdef LTC2600_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_GAP;
          gap_d   = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_q) state_d = ST_IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef LTC2600_CMD_TIMEOUT_EN
    // A new timeout in the same cycle as err_clear keeps the flag set.
    timeout_err_d = timeout_err_q;
    if (err_clear) timeout_err_d = 1'b0;
    if (tmo_hit)   timeout_err_d = 1'b1;
`endif
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      send_q    <= 1'b0;
      command_q <= '0;
      address_q <= '0;
      data_q    <= '0;
      wc_prev_q <= 1'b0;
      gap_q     <= 1'b0;
`ifdef LTC2600_CMD_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      send_q    <= send_d;
      command_q <= command_d;
      address_q <= address_d;
      data_q    <= data_d;
      wc_prev_q <= wc_prev_d;
      gap_q     <= gap_d;
`ifdef LTC2600_CMD_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule
